// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller.
//
// Purpose:
//   Selects the EX-stage operand forwarding sources, detects load-use hazards and issues
//   LOAD_LAT bubbles per hazard, and turns redirects (mispredict / loop exit) into front-end
//   flushes. It also keeps a saturating count of issued load-use bubbles.
//
// Ports:
//   i_clk, i_reset              clock (rising edge), synchronous active-low reset
//   i_rs*_addr_decode           ID-stage source registers
//   i_rs*_addr_execute          EX-stage source registers (forwarding targets)
//   i_rd_addr_{execute,memory,writeback}, i_rd_wren_*   destination register + write enable
//   i_load_execute              EX-stage instruction is a load
//   i_pc_sel, i_out_loop        redirect requests
//   o_foward_{a,b}_execution    00 regfile, 01 MEM, 10 WB
//   o_stall_{fetch,decode}      hold PC / IF-ID register
//   o_flush_{decode,execute}    clear IF-ID / ID-EX register
//   o_load_stall                FSM is in the extended load-stall state
//   o_bubble_count              saturating count of load-use bubbles
module hazard_ctrl #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_rs1_addr_decode,
  input  logic [ADDR_W-1:0] i_rs2_addr_decode,
  input  logic [ADDR_W-1:0] i_rs1_addr_execute,
  input  logic [ADDR_W-1:0] i_rs2_addr_execute,
  input  logic [ADDR_W-1:0] i_rd_addr_execute,
  input  logic [ADDR_W-1:0] i_rd_addr_memory,
  input  logic [ADDR_W-1:0] i_rd_addr_writeback,
  input  logic              i_rd_wren_execute,
  input  logic              i_rd_wren_memory,
  input  logic              i_rd_wren_writeback,
  input  logic              i_load_execute,
  input  logic              i_pc_sel,
  input  logic              i_out_loop,
  output logic [1:0]        o_foward_a_execution,
  output logic [1:0]        o_foward_b_execution,
  output logic              o_stall_fetch,
  output logic              o_stall_decode,
  output logic              o_flush_decode,
  output logic              o_flush_execute,
  output logic              o_load_stall,
  output logic [CNT_W-1:0]  o_bubble_count
);

  typedef enum logic [0:0] {StRun, StLoadStall} state_e;

  // The first bubble is issued from RUN; the counter covers the remaining LOAD_LAT-1 cycles.
  localparam logic [1:0] CntInit = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;
  localparam bit         ExtStall = (LOAD_LAT > 1);

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q;

  logic load_use;
  logic redirect;
  logic bubble;

  // MEM wins over WB: it holds the younger write to the same register.
  function automatic logic [1:0] fwd_sel(
    input logic [ADDR_W-1:0] src,
    input logic [ADDR_W-1:0] rd_mem,
    input logic              wren_mem,
    input logic [ADDR_W-1:0] rd_wb,
    input logic              wren_wb
  );
    if (src == '0)                    return 2'b00;
    else if (wren_mem && rd_mem == src) return 2'b01;
    else if (wren_wb && rd_wb == src)   return 2'b10;
    else                              return 2'b00;
  endfunction

  always_comb begin
    load_use = i_load_execute & i_rd_wren_execute & (i_rd_addr_execute != '0) &
               ((i_rd_addr_execute == i_rs1_addr_decode) |
                (i_rd_addr_execute == i_rs2_addr_decode));
    redirect = i_pc_sel | i_out_loop;
  end

  always_comb begin
    o_foward_a_execution = 2'b00;
    o_foward_b_execution = 2'b00;
    o_stall_fetch        = 1'b0;
    o_stall_decode       = 1'b0;
    o_flush_decode       = 1'b0;
    o_flush_execute      = 1'b0;
    bubble               = 1'b0;
    state_d              = state_q;
    cnt_d                = cnt_q;

    if (!i_reset) begin
      o_flush_decode  = 1'b1;
      o_flush_execute = 1'b1;
      state_d         = StRun;
      cnt_d           = 2'd0;
    end else begin
      o_foward_a_execution = fwd_sel(i_rs1_addr_execute, i_rd_addr_memory, i_rd_wren_memory,
                                     i_rd_addr_writeback, i_rd_wren_writeback);
      o_foward_b_execution = fwd_sel(i_rs2_addr_execute, i_rd_addr_memory, i_rd_wren_memory,
                                     i_rd_addr_writeback, i_rd_wren_writeback);
      unique case (state_q)
        StRun: begin
          if (redirect) begin
            // Redirect squashes the dependent instruction anyway, so no bubble is needed.
            o_flush_decode  = 1'b1;
            o_flush_execute = 1'b1;
          end else if (load_use) begin
            o_stall_fetch   = 1'b1;
            o_stall_decode  = 1'b1;
            o_flush_execute = 1'b1;
            bubble          = 1'b1;
            if (ExtStall) begin
              state_d = StLoadStall;
              cnt_d   = CntInit;
            end
          end
        end
        StLoadStall: begin
          if (redirect) begin
            o_flush_decode  = 1'b1;
            o_flush_execute = 1'b1;
            state_d         = StRun;
            cnt_d           = 2'd0;
          end else begin
            o_stall_fetch   = 1'b1;
            o_stall_decode  = 1'b1;
            o_flush_execute = 1'b1;
            bubble          = 1'b1;
            if (cnt_q == 2'd0) state_d = StRun;
            else               cnt_d   = cnt_q - 2'd1;
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q      <= StRun;
      cnt_q        <= 2'd0;
      bubble_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (bubble && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign o_load_stall   = (state_q == StLoadStall);
  assign o_bubble_count = bubble_cnt_q;

endmodule
